// File: rtl/prog_sync_fifo.sv
// Single-clock FIFO with fill level, almost-full/empty thresholds and sticky error flags.
// Define PROG_SYNC_FIFO_FWFT_EN for first-word-fall-through reads; the default is a registered read.
module prog_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 8,
  parameter int AF_LEVEL   = MEM_DEPTH - 2,
  parameter int AE_LEVEL   = 1,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  W_INC,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  R_INC,
  input  logic                  ERR_CLR,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  ALMOST_FULL,
  output logic                  ALMOST_EMPTY,
  output logic [ADDR_WIDTH:0]   FILL_LVL,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);

  localparam logic [ADDR_WIDTH:0] LP_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] LP_AF  = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] LP_AE  = (ADDR_WIDTH+1)'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
  logic [ADDR_WIDTH:0]   r_wptr;
  logic [ADDR_WIDTH:0]   r_rptr;
  logic [ADDR_WIDTH:0]   r_fill;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_af;
  logic                  r_ae;
  logic                  r_ovf;
  logic                  r_udf;

  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [ADDR_WIDTH:0]   w_wptr_nxt;
  logic [ADDR_WIDTH:0]   w_rptr_nxt;
  logic [ADDR_WIDTH:0]   w_fill_nxt;
  logic                  w_full_nxt;
  logic                  w_empty_nxt;

  // Acceptance uses the registered flags, so a rejected access never moves state.
  always_comb begin
    w_wr_acc   = W_INC & ~r_full;
    w_rd_acc   = R_INC & ~r_empty;
    w_wptr_nxt = w_wr_acc ? (r_wptr + LP_ONE) : r_wptr;
    w_rptr_nxt = w_rd_acc ? (r_rptr + LP_ONE) : r_rptr;
    w_fill_nxt = r_fill;
    unique case ({w_wr_acc, w_rd_acc})
      2'b10:   w_fill_nxt = r_fill + LP_ONE;
      2'b01:   w_fill_nxt = r_fill - LP_ONE;
      default: w_fill_nxt = r_fill;
    endcase
    w_empty_nxt = (w_wptr_nxt == w_rptr_nxt);
    w_full_nxt  = (w_wptr_nxt[ADDR_WIDTH] != w_rptr_nxt[ADDR_WIDTH]) &&
                  (w_wptr_nxt[ADDR_WIDTH-1:0] == w_rptr_nxt[ADDR_WIDTH-1:0]);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_fill  <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_af    <= 1'b0;
      r_ae    <= 1'b1;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_fill  <= w_fill_nxt;
      r_full  <= w_full_nxt;
      r_empty <= w_empty_nxt;
      r_af    <= (w_fill_nxt >= LP_AF);
      r_ae    <= (w_fill_nxt <= LP_AE);
      // A fresh error outranks a clear in the same cycle.
      r_ovf   <= (W_INC & r_full)  | (r_ovf & ~ERR_CLR);
      r_udf   <= (R_INC & r_empty) | (r_udf & ~ERR_CLR);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && w_wr_acc) begin
      r_mem[r_wptr[ADDR_WIDTH-1:0]] <= WR_DATA;
    end
  end

`ifdef PROG_SYNC_FIFO_FWFT_EN
  // Head word is presented straight from storage; R_INC only advances the pointer.
  assign RD_DATA = r_mem[r_rptr[ADDR_WIDTH-1:0]];
`else
  logic [DATA_WIDTH-1:0] r_rd_data;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rd_data <= '0;
    end else if (w_rd_acc) begin
      r_rd_data <= r_mem[r_rptr[ADDR_WIDTH-1:0]];
    end
  end

  assign RD_DATA = r_rd_data;
`endif

  assign FULL         = r_full;
  assign EMPTY        = r_empty;
  assign ALMOST_FULL  = r_af;
  assign ALMOST_EMPTY = r_ae;
  assign FILL_LVL     = r_fill;
  assign OVERFLOW     = r_ovf;
  assign UNDERFLOW    = r_udf;

endmodule

// File: tb/tb_prog_sync_fifo.sv
// Bench for prog_sync_fifo: directed vector table, then random traffic against a queue model.
module tb_prog_sync_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AFL   = 6;
  localparam int AEL   = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          w_inc = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          r_inc = 1'b0;
  logic          err_clr = 1'b0;
  logic [DW-1:0] rd_data;
  logic          full, empty, afull, aempty, ovf, udf;
  logic [3:0]    fill_lvl;

  prog_sync_fifo #(
    .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .AF_LEVEL(AFL), .AE_LEVEL(AEL)
  ) dut (
    .CLK(clk), .RST(rst), .W_INC(w_inc), .WR_DATA(wr_data), .R_INC(r_inc),
    .ERR_CLR(err_clr), .RD_DATA(rd_data), .FULL(full), .EMPTY(empty),
    .ALMOST_FULL(afull), .ALMOST_EMPTY(aempty), .FILL_LVL(fill_lvl),
    .OVERFLOW(ovf), .UNDERFLOW(udf)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: contents as a queue, plus sticky flags and last read word.
  logic [DW-1:0] q[$];
  bit            m_ovf = 0;
  bit            m_udf = 0;
  logic [DW-1:0] m_rd = '0;

  typedef struct {
    string         name;
    bit            rst, w, r, clr;
    logic [DW-1:0] d;
    int            fill;
    bit            ovf, udf;
    logic [DW-1:0] rd;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string nm, bit rs, bit w, logic [DW-1:0] d, bit r, bit c,
                              int f, bit o, bit u, logic [DW-1:0] rd);
    vec_t v;
    v.name = nm; v.rst = rs; v.w = w; v.d = d; v.r = r; v.clr = c;
    v.fill = f; v.ovf = o; v.udf = u; v.rd = rd;
    vecs.push_back(v);
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic model_step(bit rs, bit w, logic [DW-1:0] d, bit r, bit c);
    bit was_full, was_empty;
    if (rs) begin
      q.delete();
      m_ovf = 0; m_udf = 0; m_rd = '0;
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      if (r && !was_empty) m_rd = q.pop_front();
      if (w && !was_full) q.push_back(d);
      m_ovf = (w && was_full)  || (m_ovf && !c);
      m_udf = (r && was_empty) || (m_udf && !c);
    end
  endtask

  task automatic check_model(string nm);
    chk({nm, "_fill"},  32'(fill_lvl), 32'(q.size()));
    chk({nm, "_empty"}, 32'(empty),    32'(q.size() == 0));
    chk({nm, "_full"},  32'(full),     32'(q.size() == DEPTH));
    chk({nm, "_af"},    32'(afull),    32'(q.size() >= AFL));
    chk({nm, "_ae"},    32'(aempty),   32'(q.size() <= AEL));
    chk({nm, "_ovf"},   32'(ovf),      32'(m_ovf));
    chk({nm, "_udf"},   32'(udf),      32'(m_udf));
`ifdef PROG_SYNC_FIFO_FWFT_EN
    if (q.size() > 0) chk({nm, "_rd"}, 32'(rd_data), 32'(q[0]));
`else
    chk({nm, "_rd"}, 32'(rd_data), 32'(m_rd));
`endif
  endtask

  task automatic do_step(string nm, bit rs, bit w, logic [DW-1:0] d, bit r, bit c);
    @(negedge clk);
    rst = rs; w_inc = w; wr_data = d; r_inc = r; err_clr = c;
    @(posedge clk);
    #1;
    model_step(rs, w, d, r, c);
    check_model(nm);
  endtask

  initial begin
    bit            rs, w, r, c;
    logic [DW-1:0] d;
    int            wb, rb;

    add("rst", 1, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00);
    add("rst", 1, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 10; i++)
      add("fill", 0, 1, 8'(8'h10 + i), 0, 0, (i < 8) ? i + 1 : 8, i >= 8, 0, 8'h00);
    add("ovf_hold", 0, 0, 8'h00, 0, 0, 8, 1, 0, 8'h00);
    add("ovf_clr",  0, 0, 8'h00, 0, 1, 8, 0, 0, 8'h00);
    for (int i = 0; i < 10; i++)
      add("drain", 0, 0, 8'h00, 1, 0, (i < 8) ? 7 - i : 0, 0, i >= 8,
          (i < 8) ? 8'(8'h10 + i) : 8'h17);
    add("udf_clr", 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h17);
    for (int i = 0; i < 4; i++)
      add("pre4", 0, 1, 8'(8'h20 + i), 0, 0, i + 1, 0, 0, 8'h17);
    for (int i = 0; i < 20; i++)
      add("simul", 0, 1, 8'(8'h24 + i), 1, 0, 4, 0, 0, 8'(8'h20 + i));
    for (int i = 0; i < 4; i++)
      add("tofull", 0, 1, 8'(8'h40 + i), 0, 0, 5 + i, 0, 0, 8'h33);
    add("full_both", 0, 1, 8'h50, 1, 0, 7, 1, 0, 8'h34);
    add("ovf_clr2",  0, 0, 8'h00, 0, 1, 7, 0, 0, 8'h34);
    for (int i = 0; i < 7; i++)
      add("drain2", 0, 0, 8'h00, 1, 0, 6 - i, 0, 0,
          (i < 3) ? 8'(8'h35 + i) : 8'(8'h40 + i - 3));
    add("empty_both", 0, 1, 8'h60, 1, 0, 1, 0, 1, 8'h43);
    for (int i = 0; i < 7; i++)
      add("refill", 0, 1, 8'(8'h61 + i), 0, 0, 2 + i, 0, 1, 8'h43);
    add("ovf_set",    0, 1, 8'h70, 0, 0, 8, 1, 1, 8'h43);
    add("clr_vs_new", 0, 1, 8'h71, 0, 1, 8, 1, 0, 8'h43);
    add("clr_all",    0, 0, 8'h00, 0, 1, 8, 0, 0, 8'h43);
    for (int i = 0; i < 3; i++)
      add("pre5", 0, 0, 8'h00, 1, 0, 7 - i, 0, 0, 8'(8'h60 + i));
    add("rst_mid", 1, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00);
    add("wr_a5",   0, 1, 8'hA5, 0, 0, 1, 0, 0, 8'h00);
    add("rd_a5",   0, 0, 8'h00, 1, 0, 0, 0, 0, 8'hA5);

    foreach (vecs[k]) begin
      do_step(vecs[k].name, vecs[k].rst, vecs[k].w, vecs[k].d, vecs[k].r, vecs[k].clr);
      chk({vecs[k].name, "_tfill"},  32'(fill_lvl), 32'(vecs[k].fill));
      chk({vecs[k].name, "_tempty"}, 32'(empty),    32'(vecs[k].fill == 0));
      chk({vecs[k].name, "_tfull"},  32'(full),     32'(vecs[k].fill == DEPTH));
      chk({vecs[k].name, "_tovf"},   32'(ovf),      32'(vecs[k].ovf));
      chk({vecs[k].name, "_tudf"},   32'(udf),      32'(vecs[k].udf));
`ifdef PROG_SYNC_FIFO_FWFT_EN
      if (vecs[k].name == "wr_a5") chk("fwft_a5", 32'(rd_data), 32'hA5);
`else
      chk({vecs[k].name, "_trd"}, 32'(rd_data), 32'(vecs[k].rd));
`endif
    end

    // Random traffic with phase-varying bias so both full and empty are visited often.
    wb = 50; rb = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 100 == 0) begin
        wb = 20 + 30 * int'($urandom_range(2));
        rb = 20 + 30 * int'($urandom_range(2));
      end
      rs = ($urandom_range(199) == 0);
      w  = ($urandom_range(99) < wb);
      r  = ($urandom_range(99) < rb);
      c  = ($urandom_range(15) == 0);
      d  = DW'($urandom);
      do_step("rand", rs, w, d, r, c);
    end

    @(negedge clk);
    w_inc = 0; r_inc = 0; err_clr = 0; rst = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
